// File: rtl/nv_fifo_ctrl_rws_64x10_if.sv
// Handshake and RAM-port bundle for the 64x10 FIFO controller.
// master: the surrounding logic (writer, reader, RAM model); slave: the controller.
interface nv_fifo_ctrl_rws_64x10_if #(
   parameter int AW = 6,
   parameter int DW = 10
);
   logic          wr_pvld;
   logic          wr_prdy;
   logic [DW-1:0] wr_pd;
   logic          rd_pvld;
   logic          rd_prdy;
   logic [DW-1:0] rd_pd;
   logic [AW:0]   fifo_count;
   logic          ram_we;
   logic [AW-1:0] ram_wa;
   logic [DW-1:0] ram_di;
   logic          ram_re;
   logic [AW-1:0] ram_ra;
   logic [DW-1:0] ram_dout;
   logic [31:0]   pwrbus_ram_pd;
   logic [31:0]   ram_pwrbus;

   modport master (
      output wr_pvld, wr_pd, rd_prdy, ram_dout, pwrbus_ram_pd,
      input  wr_prdy, rd_pvld, rd_pd, fifo_count,
      input  ram_we, ram_wa, ram_di, ram_re, ram_ra, ram_pwrbus
   );

   modport slave (
      input  wr_pvld, wr_pd, rd_prdy, ram_dout, pwrbus_ram_pd,
      output wr_prdy, rd_pvld, rd_pd, fifo_count,
      output ram_we, ram_wa, ram_di, ram_re, ram_ra, ram_pwrbus
   );
endinterface

// File: rtl/nv_fifo_ctrl_rws_64x10.sv
// FIFO controller around a 64x10 two-port RAM with one-cycle read latency.
// A 2-entry output buffer absorbs the RAM latency so the read side can take
// one word per cycle; read issue is throttled so buffer + in-flight never exceeds 2.
module nv_fifo_ctrl_rws_64x10 #(
   parameter int DEPTH = 64,
   parameter int AW    = 6,
   parameter int DW    = 10
) (
   input  logic                       clk,
   input  logic                       reset,
   nv_fifo_ctrl_rws_64x10_if.slave    bus
);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
   logic [AW:0]   ram_cnt, ram_cnt_n;
   logic [AW:0]   fifo_cnt, fifo_cnt_n;
   logic          infl;
   logic [DW-1:0] ob0, ob1, ob0_n, ob1_n;
   logic [1:0]    ob_cnt, occ, slot;
   logic          wr_prdy_i, rd_pvld_i;
   logic          accept, pop, re;

   assign wr_prdy_i = (ram_cnt != CNT_FULL);
   assign rd_pvld_i = (ob_cnt != 2'd0);

   // Next-state: accept/pop/issue decisions, buffer capture and counters.
   always_comb begin
      accept = bus.wr_pvld & wr_prdy_i;
      pop    = rd_pvld_i & bus.rd_prdy;
      // occupancy of buffer after this cycle, counting the word landing now
      occ    = ob_cnt + {1'b0, infl} - {1'b0, pop};
      re     = (ram_cnt != '0) & ~occ[1];
      // landing slot is computed after the pop shift has been applied
      slot   = ob_cnt - {1'b0, pop};
      ob0_n  = pop ? ob1 : ob0;
      ob1_n  = ob1;
      if (infl) begin
         if (slot == 2'd0) ob0_n = bus.ram_dout;
         else              ob1_n = bus.ram_dout;
      end
      ram_cnt_n  = ram_cnt + (AW+1)'(accept) - (AW+1)'(re);
      fifo_cnt_n = fifo_cnt + (AW+1)'(accept) - (AW+1)'(pop);
      wr_ptr_n   = wr_ptr + AW'(accept);
      rd_ptr_n   = rd_ptr + AW'(re);
   end

   // State register; reset discards everything buffered or in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         ram_cnt  <= '0;
         fifo_cnt <= '0;
         infl     <= 1'b0;
         ob0      <= '0;
         ob1      <= '0;
         ob_cnt   <= 2'd0;
      end else begin
         wr_ptr   <= wr_ptr_n;
         rd_ptr   <= rd_ptr_n;
         ram_cnt  <= ram_cnt_n;
         fifo_cnt <= fifo_cnt_n;
         infl     <= re;
         ob0      <= ob0_n;
         ob1      <= ob1_n;
         ob_cnt   <= occ;
      end
   end

   assign bus.wr_prdy    = wr_prdy_i;
   assign bus.rd_pvld    = rd_pvld_i;
   assign bus.rd_pd      = ob0;
   assign bus.fifo_count = fifo_cnt;
   assign bus.ram_we     = accept;
   assign bus.ram_wa     = wr_ptr;
   assign bus.ram_di     = bus.wr_pd;
   assign bus.ram_re     = re;
   assign bus.ram_ra     = rd_ptr;
   assign bus.ram_pwrbus = bus.pwrbus_ram_pd;
endmodule

// File: doc/nv_fifo_ctrl_rws_64x10.md
Name: nv_fifo_ctrl_rws_64x10

Overview:
- Flow-controlled FIFO controller wrapped around a 64x10 two-port RAM with a registered read address.
- Accepts a valid/ready write stream and drives the RAM write and read ports.
- Absorbs the RAM's one-cycle read latency in a 2-entry output buffer, so a registered valid/ready read stream sustains one word per cycle.
- Sits upstream of the RAM (drives it) and downstream of it (consumes dout).

Parameters:
- DEPTH, 64: RAM entries; power of two; pointer width AW = log2(DEPTH).
- AW, 6: RAM address width.
- DW, 10: data width.

Ports:
- clk  input  1  core clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_pvld  input  1  write data valid.
- wr_prdy  output  1  write ready.
- wr_pd  input  DW  write payload.
- rd_pvld  output  1  read data valid (registered).
- rd_prdy  input  1  read consumer ready.
- rd_pd  output  DW  read payload (registered).
- fifo_count  output  AW+1  total entries held (RAM + in-flight + output buffer), registered.
- ram_we  output  1  RAM write enable.
- ram_wa  output  AW  RAM write address.
- ram_di  output  DW  RAM write data.
- ram_re  output  1  RAM read enable.
- ram_ra  output  AW  RAM read address.
- ram_dout  input  DW  RAM read data; valid the cycle after ram_re.
- pwrbus_ram_pd  input  32  power bus; passed to RAM unchanged, no logic.

Behaviour:
- State:
  - wr_ptr, rd_ptr: AW bits, wrap modulo DEPTH.
  - ram_cnt: 0..DEPTH, entries written but not read-issued.
  - infl: 1 bit, read issued last cycle.
  - ob[0..1] with ob_cnt 0..2: output buffer, head at ob[0].
- Reset values: all pointers and counts 0, infl=0, rd_pvld=0, rd_pd=0, fifo_count=0. Reset is honoured mid-operation; buffered contents are discarded.
- Write path:
  - wr_prdy = (ram_cnt < DEPTH), combinational from registered state (1 out of reset).
  - Accept when wr_pvld & wr_prdy: ram_we=1, ram_wa=wr_ptr, ram_di=wr_pd; wr_ptr++.
  - ram_we=0 otherwise; wa/di don't-care.
- Read issue:
  - ram_re = (ram_cnt != 0) & (ob_cnt + infl - pop < 2), where pop = rd_pvld & rd_prdy.
  - ram_ra = rd_ptr; on issue rd_ptr++; next infl = ram_re.
- Capture: when infl=1, ram_dout is written into ob at slot (ob_cnt - pop).
- Pop: on pop, ob shifts ob[1]->ob[0].
- Outputs: rd_pvld = (ob_cnt != 0); rd_pd = ob[0].
- Counts:
  - ram_cnt_next = ram_cnt + accept - ram_re.
  - fifo_count_next = fifo_count + accept - pop.
  - Maximum total occupancy is DEPTH+2; fifo_count saturates at its AW+1-bit encoding; DEPTH+2 must fit (66 < 128 at defaults).
- Latency: a word accepted in cycle c gives ram_re in c+1 (if it is the only word), capture at the end of c+2, rd_pvld=1 in c+3.
- Throughput: with rd_prdy held 1 and a continuous writer, one word per cycle in steady state, no bubbles.
- Ordering: strict FIFO; no bypass path around the RAM.
- Boundaries:
  - Simultaneous accept and ram_re when ram_cnt=DEPTH is impossible (wr_prdy=0); when ram_cnt=0 ram_re=0, so the RAM never reads an unwritten slot.
  - Simultaneous accept and read issue never target the same address.
  - Pointers wrap 63->0 silently.
  - rd_pd holds stable while rd_pvld=1 and rd_prdy=0.
- pwrbus_ram_pd has no effect on controller state.

Test Plan:
- Reset release, then single write 0x155 in cycle c -> ram_we/wa=0 in c; ram_re/ra=0 in c+1; rd_pvld=1 with rd_pd=0x155 in c+3; fifo_count 1 then 0 after pop.
- rd_prdy=0, write 0..69 continuously -> exactly 66 accepted; wr_prdy falls after 66; fifo_count=66; ram_re never issued while ob full and infl=0.
- From full, rd_prdy=1 -> outputs 0..65 in order, one per cycle, no gaps; wr_prdy rises once ram_cnt<64.
- Continuous write and read of 200 words (values i*7 mod 1024) -> in-order output, pointers wrap at least 3 times, sustained rate 1/cycle after the 3-cycle fill.
- Random rd_prdy toggling (50%) with burst writes -> rd_pd stable while stalled, no loss or duplication, scoreboard match.
- Assert reset with 10 words buffered and infl=1 -> rd_pvld=0, fifo_count=0 immediately; the first post-reset write appears as the first output.
